wdata_block_sequencer: RTL and testbench

// Sequential successor of the single-block write-data assembler in the load/store unit.
// - Accepts one warp store: active mask, per-thread data, write width and per-thread byte address.
// - Splits it into one memory write per distinct block touched, emitted in thread order.
// - Each beat has a full block of merged data and byte-enables.
// - Sits between the coalesce stage and the memory request interface; owns the valid/ready handshake on both sides.

---
 rtl/wdata_block_sequencer.sv | 157 +++++++++++++++
 tb/tb_wdata_block_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdata_block_sequencer.sv
// Warp store sequencer: splits one captured store into one merged memory write
// per distinct block touched, issued in thread order with valid/ready on both sides.
module wdata_block_sequencer #(
   parameter int RegWidth     = 32,
   parameter int WarpWidth    = 4,
   parameter int AddressWidth = 32,
   parameter int BlockIdxBits = 4,
   parameter int TagWidth     = 4,
   localparam int BlockWidth  = 1 << BlockIdxBits,
   localparam int WidthBits   = (RegWidth / 8 > 1) ? $clog2(RegWidth / 8) : 1,
   localparam int BlkAddrW    = AddressWidth - BlockIdxBits
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_valid_i,
   output logic                              req_ready_o,
   input  logic [TagWidth-1:0]               req_tag_i,
   input  logic [WarpWidth-1:0]              req_we_mask_i,
   input  logic [RegWidth*WarpWidth-1:0]     req_wdata_i,
   input  logic [WidthBits-1:0]              req_write_width_i,
   input  logic [WarpWidth*AddressWidth-1:0] req_addr_i,
   output logic                              mem_valid_o,
   input  logic                              mem_ready_i,
   output logic [BlkAddrW-1:0]               mem_block_addr_o,
   output logic [BlockWidth-1:0]             mem_we_mask_o,
   output logic [8*BlockWidth-1:0]           mem_wdata_o,
   output logic [TagWidth-1:0]               mem_tag_o,
   output logic                              mem_last_o
);

   localparam int RegBytes  = RegWidth / 8;
   localparam int BlockBits = 8 * BlockWidth;
   localparam int LeadW     = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]                             state;
   logic [TagWidth-1:0]                    tag_q;
   logic [WarpWidth-1:0][RegWidth-1:0]     wdata_q;
   logic [WidthBits-1:0]                   width_q;
   logic [WarpWidth-1:0][AddressWidth-1:0] addr_q;
   logic [WarpWidth-1:0]                   pending_q;

   logic [LeadW-1:0]      leader;
   logic [BlkAddrW-1:0]   lead_blk;
   logic [WarpWidth-1:0]  group;
   logic                  issue;
   logic                  last_beat;
   logic                  accept;
   logic                  beat_fire;
   logic [RegBytes-1:0]   byte_mask;
   logic [RegWidth-1:0]   reg_mask;
   logic [BlockWidth-1:0] be;
   logic [BlockBits-1:0]  data;

   always_comb begin
      leader = '0;
      for (int t = WarpWidth - 1; t >= 0; t--) begin
         if (pending_q[t]) leader = LeadW'(t);
      end
   end

   assign lead_blk = addr_q[leader][AddressWidth-1:BlockIdxBits];

   always_comb begin
      group = '0;
      for (int t = 0; t < WarpWidth; t++) begin
         group[t] = pending_q[t] && (addr_q[t][AddressWidth-1:BlockIdxBits] == lead_blk);
      end
   end

   always_comb begin
      byte_mask = '0;
      reg_mask  = '0;
      for (int b = 0; b < RegBytes; b++) begin
         byte_mask[b]         = (32'(b) < (32'd1 << width_q));
         reg_mask[b*8 +: 8]   = {8{byte_mask[b]}};
      end
   end

   // Threads merge in ascending order so the highest index overwrites shared bytes.
   always_comb begin
      logic [BlockWidth-1:0] m_ext;
      logic [BlockBits-1:0]  d_ext;
      logic [BlockBits-1:0]  m_bits;
      be     = '0;
      data   = '0;
      m_ext  = '0;
      d_ext  = '0;
      m_bits = '0;
      for (int t = 0; t < WarpWidth; t++) begin
         if (group[t]) begin
            m_ext = BlockWidth'(byte_mask) << addr_q[t][BlockIdxBits-1:0];
            d_ext = BlockBits'(wdata_q[t] & reg_mask) << {addr_q[t][BlockIdxBits-1:0], 3'b000};
            for (int p = 0; p < BlockWidth; p++) begin
               m_bits[p*8 +: 8] = {8{m_ext[p]}};
            end
            data = (data & ~m_bits) | d_ext;
            be   = be | m_ext;
         end
      end
   end

   // Handshake: a transfer happens on a rising clk_i edge where valid && ready.
   // mem_* hold steady while mem_valid_o && !mem_ready_i. req_ready_o also rises
   // combinationally from mem_ready_i while the last beat retires, so a new store
   // can be captured in that same cycle.
   assign issue     = (state == ST_ISSUE);
   assign last_beat = ((pending_q & ~group) == '0);
   assign mem_valid_o = issue && !rst_i;
   assign mem_last_o  = issue && last_beat;
   assign req_ready_o = !rst_i && (!issue || (mem_ready_i && last_beat));
   assign accept      = req_valid_i && req_ready_o;
   assign beat_fire   = mem_valid_o && mem_ready_i;

   assign mem_block_addr_o = lead_blk;
   assign mem_we_mask_o    = be;
   assign mem_wdata_o      = data;
   assign mem_tag_o        = tag_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         tag_q     <= '0;
         wdata_q   <= '0;
         width_q   <= '0;
         addr_q    <= '0;
         pending_q <= '0;
      end else if (accept) begin
         state     <= ST_ISSUE;
         tag_q     <= req_tag_i;
         wdata_q   <= req_wdata_i;
         width_q   <= req_write_width_i;
         addr_q    <= req_addr_i;
         pending_q <= req_we_mask_i;
      end else if (beat_fire) begin
         pending_q <= pending_q & ~group;
         if (last_beat) state <= ST_IDLE;
      end
   end

   logic [BlockIdxBits-1:0] align_m;
   logic                    misaligned;

   always_comb begin
      align_m    = BlockIdxBits'((32'd1 << req_write_width_i) - 32'd1);
      misaligned = 1'b0;
      for (int t = 0; t < WarpWidth; t++) begin
         if (req_we_mask_i[t] && ((req_addr_i[t*AddressWidth +: BlockIdxBits] & align_m) != '0))
            misaligned = 1'b1;
      end
   end

   a_thread_aligned : assert property (@(posedge clk_i) disable iff (rst_i) !(accept && misaligned));

endmodule

// File: tb/tb_wdata_block_sequencer.sv
// Self-checking bench for wdata_block_sequencer: directed scenarios plus a
// random phase, beats checked against an expected-beat queue.
module tb_wdata_block_sequencer;

   localparam int BA_W   = 28;
   localparam int BEAT_W = BA_W + 16 + 128 + 4 + 1;

   logic         clk_i;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [3:0]   req_tag_i;
   logic [3:0]   req_we_mask_i;
   logic [127:0] req_wdata_i;
   logic [1:0]   req_write_width_i;
   logic [127:0] req_addr_i;
   logic         mem_valid_o;
   logic         mem_ready_i;
   logic [27:0]  mem_block_addr_o;
   logic [15:0]  mem_we_mask_o;
   logic [127:0] mem_wdata_o;
   logic [3:0]   mem_tag_o;
   logic         mem_last_o;

   wdata_block_sequencer dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_tag_i         (req_tag_i),
      .req_we_mask_i     (req_we_mask_i),
      .req_wdata_i       (req_wdata_i),
      .req_write_width_i (req_write_width_i),
      .req_addr_i        (req_addr_i),
      .mem_valid_o       (mem_valid_o),
      .mem_ready_i       (mem_ready_i),
      .mem_block_addr_o  (mem_block_addr_o),
      .mem_we_mask_o     (mem_we_mask_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_tag_o         (mem_tag_o),
      .mem_last_o        (mem_last_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   logic [BEAT_W-1:0] exp_q[$];

   localparam logic [127:0] DATA_SEQ = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
   localparam logic [127:0] ADDR_ONE = {32'h10C, 32'h108, 32'h104, 32'h100};
   localparam logic [127:0] ADDR_SPL = {32'h20C, 32'h108, 32'h204, 32'h100};

   function automatic logic [BEAT_W-1:0] pack_beat(input logic [27:0] blk, input logic [15:0] we,
                                                   input logic [127:0] d, input logic [3:0] tag,
                                                   input logic last);
      return {blk, we, d, tag, last};
   endfunction

   logic [BEAT_W-1:0] act_beat;
   assign act_beat = {mem_block_addr_o, mem_we_mask_o, mem_wdata_o, mem_tag_o, mem_last_o};

   // scoreboard monitor: beats retire on the next posedge when valid && ready here
   logic              stall_prev = 1'b0;
   logic [BEAT_W-1:0] stall_snap;
   always @(negedge clk_i) begin
      logic [BEAT_W-1:0] exp_b;
      if (stall_prev && !rst_i) begin
         checks++;
         if (mem_valid_o !== 1'b1 || act_beat !== stall_snap) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b beat=%h, required valid=1 beat=%h",
                     mem_valid_o, act_beat, stall_snap);
         end
      end
      stall_prev = mem_valid_o && !mem_ready_i;
      stall_snap = act_beat;
      if (mem_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, required no beat", act_beat);
         end else begin
            exp_b = exp_q.pop_front();
            if (act_beat !== exp_b) begin
               errors++;
               $display("FAIL beat: got %h, required %h", act_beat, exp_b);
            end
         end
      end
   end

   // reference model: byte-by-byte merge of each block group in thread order
   task automatic model_push(input logic [3:0] tag, input logic [3:0] mask, input logic [127:0] data,
                             input logic [1:0] width, input logic [127:0] addr);
      logic [3:0]   pend;
      logic [27:0]  blk;
      logic [15:0]  we;
      logic [127:0] d;
      logic [31:0]  a;
      int           lead;
      int           off;
      pend = mask;
      if (mask == 4'b0) begin
         a = addr[31:0];
         exp_q.push_back(pack_beat(a[31:4], 16'h0, 128'h0, tag, 1'b1));
      end
      while (pend != 4'b0) begin
         lead = 0;
         for (int t = 3; t >= 0; t--) if (pend[t]) lead = t;
         a   = addr[lead*32 +: 32];
         blk = a[31:4];
         we  = '0;
         d   = '0;
         for (int t = 0; t < 4; t++) begin
            a = addr[t*32 +: 32];
            if (pend[t] && a[31:4] == blk) begin
               for (int b = 0; b < (1 << width); b++) begin
                  off = int'(a[3:0]) + b;
                  we[off] = 1'b1;
                  d[off*8 +: 8] = data[t*32 + b*8 +: 8];
               end
               pend[t] = 1'b0;
            end
         end
         exp_q.push_back(pack_beat(blk, we, d, tag, pend == 4'b0));
      end
   endtask

   // driver: call at posedge+#1, returns at posedge+#1 right after the capture edge
   task automatic drive_req(input logic [3:0] tag, input logic [3:0] mask, input logic [127:0] data,
                            input logic [1:0] width, input logic [127:0] addr, output int waited);
      req_valid_i       = 1'b1;
      req_tag_i         = tag;
      req_we_mask_i     = mask;
      req_wdata_i       = data;
      req_write_width_i = width;
      req_addr_i        = addr;
      waited = 0;
      while (1) begin
         @(negedge clk_i);
         if (req_ready_o === 1'b1 || waited >= 100) break;
         waited++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL req_accept: got ready=%0b after %0d cycles, required ready=1", req_ready_o, waited);
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input bit rand_ready);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         if (rand_ready) mem_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk_i); #1;
         n++;
      end
      mem_ready_i = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk_i);
      checks++;
      if (mem_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL extra_beat: got mem_valid=%0b, required 0", mem_valid_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      checks++;
      if (mem_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got valid=%0b ready=%0b, required 0 0", mem_valid_o, req_ready_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1 || mem_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got ready=%0b valid=%0b, required 1 0", req_ready_o, mem_valid_o);
      end
      checks++;
      if (act_beat !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", act_beat);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_one_block();
      int w;
      mem_ready_i = 1'b1;
      exp_q.push_back(pack_beat(28'h10, 16'hFFFF, DATA_SEQ, 4'h5, 1'b1));
      drive_req(4'h5, 4'hF, DATA_SEQ, 2'd2, ADDR_ONE, w);
      @(negedge clk_i);
      checks++;
      if (mem_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL first_beat_latency: got valid=%0b, required 1", mem_valid_o);
      end
      @(posedge clk_i); #1;
      wait_drain(1'b0);
   endtask

   task automatic test_split();
      int w;
      mem_ready_i = 1'b1;
      exp_q.push_back(pack_beat(28'h10, 16'h0F0F, {32'h0, 32'h0B0A0908, 32'h0, 32'h03020100}, 4'h6, 1'b0));
      exp_q.push_back(pack_beat(28'h20, 16'hF0F0, {32'h0F0E0D0C, 32'h0, 32'h07060504, 32'h0}, 4'h6, 1'b1));
      drive_req(4'h6, 4'hF, DATA_SEQ, 2'd2, ADDR_SPL, w);
      wait_drain(1'b0);
   endtask

   task automatic test_byte_conflict();
      int w;
      mem_ready_i = 1'b1;
      exp_q.push_back(pack_beat(28'h3, 16'h0008, 128'hDD000000, 4'h7, 1'b1));
      drive_req(4'h7, 4'hF, {32'h445566DD, 32'h334455CC, 32'h223344BB, 32'h112233AA}, 2'd0,
                {32'h33, 32'h33, 32'h33, 32'h33}, w);
      wait_drain(1'b0);
   endtask

   task automatic test_backpressure();
      int w;
      mem_ready_i = 1'b0;
      exp_q.push_back(pack_beat(28'h10, 16'h0F0F, {32'h0, 32'h0B0A0908, 32'h0, 32'h03020100}, 4'h8, 1'b0));
      exp_q.push_back(pack_beat(28'h20, 16'hF0F0, {32'h0F0E0D0C, 32'h0, 32'h07060504, 32'h0}, 4'h8, 1'b1));
      drive_req(4'h8, 4'hF, DATA_SEQ, 2'd2, ADDR_SPL, w);
      for (int beat = 0; beat < 2; beat++) begin
         repeat (3) begin
            @(negedge clk_i);
            checks++;
            if (mem_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin
               errors++;
               $display("FAIL bp_stall: beat %0d got valid=%0b ready=%0b, required 1 0",
                        beat, mem_valid_o, req_ready_o);
            end
            @(posedge clk_i); #1;
         end
         mem_ready_i = 1'b1;
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== (beat == 1)) begin
            errors++;
            $display("FAIL bp_ready_at_retire: beat %0d got ready=%0b, required %0b",
                     beat, req_ready_o, beat == 1);
         end
         @(posedge clk_i); #1;
         mem_ready_i = 1'b0;
      end
      repeat (3) begin
         @(negedge clk_i);
         checks++;
         if (mem_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_beat_count: got valid=%0b after 2 beats, required 0", mem_valid_o);
         end
      end
      @(posedge clk_i); #1;
      wait_drain(1'b0);
   endtask

   task automatic test_back_to_back();
      int w1;
      int w2;
      mem_ready_i = 1'b1;
      exp_q.push_back(pack_beat(28'h55, 16'h0, 128'h0, 4'h1, 1'b1));
      exp_q.push_back(pack_beat(28'h10, 16'hFFFF, DATA_SEQ, 4'h9, 1'b1));
      drive_req(4'h1, 4'h0, DATA_SEQ, 2'd2, {32'h0, 32'h0, 32'h0, 32'h550}, w1);
      drive_req(4'h9, 4'hF, DATA_SEQ, 2'd2, ADDR_ONE, w2);
      checks++;
      if (w2 !== 0) begin
         errors++;
         $display("FAIL b2b_accept: got %0d wait cycles, required 0", w2);
      end
      @(negedge clk_i);
      checks++;
      if (mem_valid_o !== 1'b1 || mem_tag_o !== 4'h9) begin
         errors++;
         $display("FAIL b2b_next_beat: got valid=%0b tag=%h, required 1 9", mem_valid_o, mem_tag_o);
      end
      @(posedge clk_i); #1;
      wait_drain(1'b0);
   endtask

   task automatic test_reset_mid_issue();
      int w;
      bit seen;
      mem_ready_i = 1'b1;
      exp_q.push_back(pack_beat(28'h10, 16'h0F0F, {32'h0, 32'h0B0A0908, 32'h0, 32'h03020100}, 4'hA, 1'b0));
      drive_req(4'hA, 4'hF, DATA_SEQ, 2'd2, ADDR_SPL, w);
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (mem_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_hold: got valid=%0b ready=%0b, required 0 0", mem_valid_o, req_ready_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 1'b1 || mem_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: got ready=%0b valid=%0b, required 1 0", req_ready_o, mem_valid_o);
      end
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         if (mem_valid_o !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL mid_reset_discard: got a beat after reset, required none");
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_beat0: got %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_random();
      int           w;
      logic [3:0]   tag;
      logic [3:0]   mask;
      logic [1:0]   width;
      logic [127:0] data;
      logic [127:0] addr;
      logic [27:0]  blk;
      logic [3:0]   off;
      for (int n = 0; n < 30; n++) begin
         tag   = 4'($urandom_range(0, 15));
         mask  = 4'($urandom_range(0, 15));
         width = 2'($urandom_range(0, 2));
         for (int t = 0; t < 4; t++) begin
            blk = 28'h0ABCDE0 + 28'($urandom_range(0, 2));
            off = 4'(($urandom_range(0, 15) >> width) << width);
            addr[t*32 +: 32] = {blk, off};
            data[t*32 +: 32] = $urandom;
         end
         model_push(tag, mask, data, width, addr);
         drive_req(tag, mask, data, width, addr, w);
         wait_drain(1'b1);
      end
   endtask

   initial begin
      rst_i             = 1'b1;
      req_valid_i       = 1'b0;
      req_tag_i         = '0;
      req_we_mask_i     = '0;
      req_wdata_i       = '0;
      req_write_width_i = '0;
      req_addr_i        = '0;
      mem_ready_i       = 1'b0;
      test_reset();
      test_one_block();
      test_split();
      test_byte_conflict();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_issue();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
